// File: rtl/dqs_write_preamble_gen.sv
// -----------------------------------------------------------------------------
// dqs_write_preamble_gen
//
// Write-path DQS strobe generator. Once a write request is accepted, the block
// waits the programmed write latency. It then drives a preamble, a toggling
// burst strobe and a postamble on DQS_AD, one UI per clk_i cycle. Every
// preamble ends in "10" so the read-side detector can lock onto it.
//
// Ports
//   clk_i             : UI-rate clock, one DQS UI per cycle
//   reset_n_i         : asynchronous active-low reset
//   en_i              : block enable; gates acceptance only
//   wr_req_i          : write request, accepted when wr_req_i && ready_o
//   wr_lat_i[4:0]     : idle UIs between acceptance and the first preamble UI
//   pre_amble_sett_i  : preamble select (000/001/010/011; 1xx behaves as 000)
//   burst_len_i       : 0 = BL8, 1 = BL16
//   post_amble_sett_i : 0 = 1-UI postamble "0", 1 = 3-UI postamble "010"
//   ready_o           : combinational; a request can be accepted this cycle
//   DQS_AD            : registered strobe level
//   dqs_oe_o          : registered DQS output enable (whole driven window)
//   data_valid_o      : registered; high on every burst UI
//   done_o            : registered one-cycle pulse in the first IDLE after POST
// -----------------------------------------------------------------------------
module dqs_write_preamble_gen (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       en_i,
    input  logic       wr_req_i,
    input  logic [4:0] wr_lat_i,
    input  logic [2:0] pre_amble_sett_i,
    input  logic       burst_len_i,
    input  logic       post_amble_sett_i,
    output logic       ready_o,
    output logic       DQS_AD,
    output logic       dqs_oe_o,
    output logic       data_valid_o,
    output logic       done_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_PRE   = 3'd2,
        ST_BURST = 3'd3,
        ST_POST  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] cnt_q,   cnt_d;
    logic [1:0] pre_q,   pre_d;
    logic       bl_q,    bl_d;
    logic       post_q,  post_d;

    logic       dqs_q,   dqs_d;
    logic       oe_q,    oe_d;
    logic       dv_q,    dv_d;
    logic       done_q,  done_d;

    logic       accept;

    // Reserved preamble codes (1xx) fall back to the 2-UI "10" preamble.
    function automatic logic [1:0] pre_sel(input logic [2:0] sett);
        return sett[2] ? 2'b00 : sett[1:0];
    endfunction

    // Preamble length is 2*(sel+1) UIs, so the counter load value is 2*sel+1.
    function automatic logic [4:0] pre_load(input logic [1:0] sel);
        return {2'b00, sel, 1'b1};
    endfunction

    function automatic logic [4:0] burst_load(input logic bl);
        return bl ? 5'd15 : 5'd7;
    endfunction

    function automatic logic [4:0] post_load(input logic post);
        return post ? 5'd2 : 5'd0;
    endfunction

    // The seamless slot is only offered for zero-latency requests. Any other
    // latency would need a gap that the running burst cannot provide.
    assign ready_o = en_i &&
                     ((state_q == ST_IDLE) ||
                      ((state_q == ST_BURST) && (cnt_q == 5'd0) && (wr_lat_i == 5'd0)));

    assign accept = wr_req_i && ready_o;

    // Next state / counter / latched settings
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        bl_d    = bl_q;
        post_d  = post_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    pre_d  = pre_sel(pre_amble_sett_i);
                    bl_d   = burst_len_i;
                    post_d = post_amble_sett_i;
                    if (wr_lat_i != 5'd0) begin
                        state_d = ST_WAIT;
                        cnt_d   = wr_lat_i - 5'd1;
                    end else begin
                        state_d = ST_PRE;
                        cnt_d   = pre_load(pre_sel(pre_amble_sett_i));
                    end
                end
            end

            ST_WAIT: begin
                if (cnt_q == 5'd0) begin
                    state_d = ST_PRE;
                    cnt_d   = pre_load(pre_q);
                end else begin
                    cnt_d   = cnt_q - 5'd1;
                end
            end

            ST_PRE: begin
                if (cnt_q == 5'd0) begin
                    state_d = ST_BURST;
                    cnt_d   = burst_load(bl_q);
                end else begin
                    cnt_d   = cnt_q - 5'd1;
                end
            end

            ST_BURST: begin
                if (cnt_q == 5'd0) begin
                    if (accept) begin
                        // Seamless write: restart the burst directly with the
                        // new settings and skip both postamble and preamble.
                        pre_d   = pre_sel(pre_amble_sett_i);
                        bl_d    = burst_len_i;
                        post_d  = post_amble_sett_i;
                        state_d = ST_BURST;
                        cnt_d   = burst_load(burst_len_i);
                    end else begin
                        state_d = ST_POST;
                        cnt_d   = post_load(post_q);
                    end
                end else begin
                    cnt_d   = cnt_q - 5'd1;
                end
            end

            ST_POST: begin
                if (cnt_q == 5'd0) begin
                    state_d = ST_IDLE;
                    cnt_d   = 5'd0;
                end else begin
                    cnt_d   = cnt_q - 5'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = 5'd0;
            end
        endcase
    end

    // Output decode from the upcoming state, so the registered outputs line
    // up with the UI that state represents.
    //   PRE   : high UIs sit at counter 1, and also at 3 for the 6/8-UI
    //           preambles, giving the trailing "10" / "1010".
    //   BURST : load values are odd, so counter[0] starts the burst at 1.
    //   POST  : "010" has its single high UI at counter 1.
    always_comb begin
        dqs_d  = 1'b0;
        oe_d   = 1'b0;
        dv_d   = 1'b0;
        done_d = (state_q == ST_POST) && (state_d == ST_IDLE);

        case (state_d)
            ST_PRE: begin
                oe_d  = 1'b1;
                dqs_d = (cnt_d == 5'd1) || ((cnt_d == 5'd3) && pre_d[1]);
            end
            ST_BURST: begin
                oe_d  = 1'b1;
                dv_d  = 1'b1;
                dqs_d = cnt_d[0];
            end
            ST_POST: begin
                oe_d  = 1'b1;
                dqs_d = (cnt_d == 5'd1);
            end
            default: begin
                dqs_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            pre_q   <= 2'b00;
            bl_q    <= 1'b0;
            post_q  <= 1'b0;
            dqs_q   <= 1'b0;
            oe_q    <= 1'b0;
            dv_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            bl_q    <= bl_d;
            post_q  <= post_d;
            dqs_q   <= dqs_d;
            oe_q    <= oe_d;
            dv_q    <= dv_d;
            done_q  <= done_d;
        end
    end

    assign DQS_AD       = dqs_q;
    assign dqs_oe_o     = oe_q;
    assign data_valid_o = dv_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_dqs_write_preamble_gen.sv
module tb_dqs_write_preamble_gen;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic       wr_req;
    logic [4:0] wr_lat;
    logic [2:0] pre;
    logic       bl;
    logic       post;
    logic       ready;
    logic       dqs;
    logic       oe;
    logic       dv;
    logic       done;

    int total  = 0;
    int passed = 0;

    dqs_write_preamble_gen dut (
        .clk_i             (clk),
        .reset_n_i         (reset_n),
        .en_i              (en),
        .wr_req_i          (wr_req),
        .wr_lat_i          (wr_lat),
        .pre_amble_sett_i  (pre),
        .burst_len_i       (bl),
        .post_amble_sett_i (post),
        .ready_o           (ready),
        .DQS_AD            (dqs),
        .dqs_oe_o          (oe),
        .data_valid_o      (dv),
        .done_o            (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; afterwards we sit in cycle 1 after accept.
    task automatic start_req(input logic [4:0] lat, input logic [2:0] p,
                             input logic b, input logic po);
        wr_lat = lat; pre = p; bl = b; post = po; wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] act;
        reset_n = 1'b0; en = 1'b0; wr_req = 1'b0;
        wr_lat = '0; pre = '0; bl = 1'b0; post = 1'b0;
        tick(); tick();
        act = {dqs, oe, dv, done};
        total++;
        if (act !== 4'b0000) $display("FAIL reset_outputs: got %b expected 0000", act);
        else passed++;
        reset_n = 1'b1;
        tick();
        total++;
        if (ready !== 1'b0) $display("FAIL reset_ready_en0: got %b expected 0", ready);
        else passed++;
        en = 1'b1;
        #1;
        total++;
        if (ready !== 1'b1) $display("FAIL ready_same_cycle_en: got %b expected 1", ready);
        else passed++;
    endtask

    task automatic test_bl8_basic();
        logic [10:0] exp_dqs;
        logic [3:0]  e, a;
        exp_dqs = 11'b10101010100;
        start_req(5'd0, 3'b000, 1'b0, 1'b0);
        for (int k = 1; k <= 13; k++) begin
            if (k <= 11) e = {exp_dqs[11-k], 1'b1, (k >= 3 && k <= 10), 1'b0};
            else         e = {3'b000, (k == 12)};
            a = {dqs, oe, dv, done};
            total++;
            if (a !== e) $display("FAIL bl8_basic cyc%0d: dqs/oe/dv/done got %b expected %b", k, a, e);
            else passed++;
            tick();
        end
    endtask

    task automatic test_bl16_wait();
        logic [26:0] exp_dqs;
        logic [3:0]  e, a;
        int idx;
        exp_dqs = 27'b00001010_1010101010101010_010;
        start_req(5'd5, 3'b011, 1'b1, 1'b1);
        // Changing inputs after acceptance must not affect the sequence.
        wr_lat = 5'd0; pre = 3'b000; bl = 1'b0; post = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            idx = k - 6;
            if (k <= 5)       e = 4'b0000;
            else if (k <= 32) e = {exp_dqs[26-idx], 1'b1, (idx >= 8 && idx < 24), 1'b0};
            else              e = {3'b000, (k == 33)};
            a = {dqs, oe, dv, done};
            total++;
            if (a !== e) $display("FAIL bl16_wait cyc%0d: dqs/oe/dv/done got %b expected %b", k, a, e);
            else passed++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [18:0] exp_dqs;
        logic [3:0]  e, a;
        int n_done;
        exp_dqs = 19'b10_1010101010101010_0;
        n_done = 0;
        start_req(5'd0, 3'b000, 1'b0, 1'b0);
        for (int k = 1; k <= 22; k++) begin
            if (k <= 19) e = {exp_dqs[19-k], 1'b1, (k >= 3 && k <= 18), 1'b0};
            else         e = {3'b000, (k == 20)};
            a = {dqs, oe, dv, done};
            if (done === 1'b1) n_done++;
            total++;
            if (a !== e) $display("FAIL back_to_back cyc%0d: dqs/oe/dv/done got %b expected %b", k, a, e);
            else passed++;
            if (k == 10) begin
                wr_lat = 5'd0; bl = 1'b0; post = 1'b0; wr_req = 1'b1;
                #1;
                total++;
                if (ready !== 1'b1) $display("FAIL b2b_ready: got %b expected 1", ready);
                else passed++;
            end
            if (k == 11) wr_req = 1'b0;
            tick();
        end
        total++;
        if (n_done != 1) $display("FAIL b2b_done_count: got %0d expected 1", n_done);
        else passed++;
    endtask

    task automatic test_no_seamless_lat3();
        logic [10:0] exp_dqs;
        logic [3:0]  e, a;
        exp_dqs = 11'b10101010100;
        start_req(5'd0, 3'b000, 1'b0, 1'b0);
        for (int k = 1; k <= 17; k++) begin
            if (k <= 11) e = {exp_dqs[11-k], 1'b1, (k >= 3 && k <= 10), 1'b0};
            else         e = {3'b000, (k == 12)};
            a = {dqs, oe, dv, done};
            total++;
            if (a !== e) $display("FAIL no_seamless cyc%0d: dqs/oe/dv/done got %b expected %b", k, a, e);
            else passed++;
            if (k == 10) begin
                wr_lat = 5'd3; wr_req = 1'b1;
                #1;
                total++;
                if (ready !== 1'b0) $display("FAIL lat3_ready: got %b expected 0", ready);
                else passed++;
            end
            if (k == 11) begin
                wr_req = 1'b0; wr_lat = 5'd0;
            end
            tick();
        end
    endtask

    task automatic test_reserved_pre();
        logic [12:0] exp_dqs;
        logic [3:0]  e, a;
        exp_dqs = 13'b10_10101010_010;
        start_req(5'd0, 3'b110, 1'b0, 1'b1);
        for (int k = 1; k <= 15; k++) begin
            if (k <= 13) e = {exp_dqs[13-k], 1'b1, (k >= 3 && k <= 10), 1'b0};
            else         e = {3'b000, (k == 14)};
            a = {dqs, oe, dv, done};
            total++;
            if (a !== e) $display("FAIL reserved_pre cyc%0d: dqs/oe/dv/done got %b expected %b", k, a, e);
            else passed++;
            tick();
        end
    endtask

    task automatic test_en_low();
        logic [3:0] a;
        en = 1'b0;
        #1;
        total++;
        if (ready !== 1'b0) $display("FAIL en_low_ready: got %b expected 0", ready);
        else passed++;
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            a = {dqs, oe, dv, done};
            total++;
            if (a !== 4'b0000) $display("FAIL en_low_ignored cyc%0d: got %b expected 0000", k, a);
            else passed++;
            tick();
        end
        en = 1'b1;
        #1;
        total++;
        if (ready !== 1'b1) $display("FAIL en_rise_ready: got %b expected 1", ready);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [12:0] exp_dqs;
        logic [3:0]  e, a;
        start_req(5'd0, 3'b000, 1'b1, 1'b0);
        repeat (5) tick();
        // cycle 6: inside the BL16 burst
        total++;
        if (oe !== 1'b1 || dv !== 1'b1) $display("FAIL rst_mid_pre: oe/dv got %b%b expected 11", oe, dv);
        else passed++;
        reset_n = 1'b0; wr_req = 1'b1;
        #1;
        a = {dqs, oe, dv, done};
        total++;
        if (a !== 4'b0000) $display("FAIL rst_mid_async: got %b expected 0000", a);
        else passed++;
        tick();
        reset_n = 1'b1; wr_req = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            tick();
            a = {dqs, oe, dv, done};
            total++;
            if (a !== 4'b0000) $display("FAIL rst_req_dropped cyc%0d: got %b expected 0000", k, a);
            else passed++;
        end
        exp_dqs = 13'b0010_10101010_0;
        start_req(5'd2, 3'b001, 1'b0, 1'b0);
        for (int k = 1; k <= 17; k++) begin
            if (k <= 2)       e = 4'b0000;
            else if (k <= 15) e = {exp_dqs[15-k], 1'b1, (k >= 7 && k <= 14), 1'b0};
            else              e = {3'b000, (k == 16)};
            a = {dqs, oe, dv, done};
            total++;
            if (a !== e) $display("FAIL after_reset cyc%0d: dqs/oe/dv/done got %b expected %b", k, a, e);
            else passed++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_bl8_basic();
        test_bl16_wait();
        test_back_to_back();
        test_no_seamless_lat3();
        test_reserved_pre();
        test_en_low();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
